monitor_channel_arbiter: RTL and testbench
==========================================

Name: monitor_channel_arbiter

Overview:
- Schedules monitor channel I/O cycles (MRCH/MWCH) on the AGC monitor interface.
- Shares the one interface between NREQ requesters: host control port, downlink drain, DSKY/keyer stimulus, and others.
- Drives mrch/mwch/ch/mwl for a fixed number of monwt strobes, captures read data, then returns a per-requester completion pulse.
- Sits between the host bus decoders and the monitor channel shadow/register logic.

Parameters:
- NREQ, 3, number of requesters (2..8).
- HOLD_STROBES, 2, monwt strobes the command is held; data is captured on the last one.
- TIMEOUT_CYC, 1024, clk cycles allowed between strobes before abort (TIMEOUT_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until its ack.
- req_we  in  NREQ  1 = write channel (MWCH), 0 = read (MRCH).
- req_ch  in  NREQ*9  channel number per requester; slice i = bits [9i+8:9i].
- req_wdata  in  NREQ*15  write data per requester.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack; 1 = transaction aborted by timeout.
- rdata  out  15  read data; valid with ack on reads, held until the next capture.
- busy  out  1  transaction in progress.
- monwt  in  1  single-clk monitor write-timing strobe, already synchronous to clk.
- mdata  in  15  channel data returned by the AGC, valid in the monwt cycle.
- mrch  out  1  monitor read-channel command.
- mwch  out  1  monitor write-channel command.
- ch  out  9  channel address.
- mwl  out  15  monitor write-line data.

Behaviour:
- Reset values: ack=0, err=0, rdata=0, busy=0, mrch=0, mwch=0, ch=0, mwl=0; state=IDLE; rr pointer=0; counters=0.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, grant by round-robin starting at index rr.
  - Latch the grantee's index, we, ch and wdata into internal registers; requester inputs are not sampled again for this transaction.
  - Go to ISSUE. No req -> stay in IDLE.
- ISSUE (1 cycle):
  - Drive ch, mwl (0 on reads), and mrch = ~we or mwch = we from the latched values.
  - Clear the strobe counter and timeout counter; busy=1. Go to WAIT.
- WAIT:
  - Command outputs are held stable.
  - Each monwt increments the strobe counter.
  - On the HOLD_STROBES-th strobe: capture mdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
  - A monwt in the ISSUE cycle is ignored; counting starts in WAIT.
- DONE (1 cycle):
  - mrch=mwch=0, ch/mwl return to 0.
  - ack[grantee]=1, err per abort flag, busy=0.
  - rr = grantee+1, wrapping NREQ-1 -> 0.
  - Go to IDLE.
  - The first re-arbitration therefore happens 1 cycle after ack, which guarantees one idle clk between commands.
- Latency: with continuous monwt, ack comes HOLD_STROBES+2 cycles after the grant cycle.
- A requester that drops req mid-transaction does not abort it; its ack is still issued.
- If req is still set in the cycle after ack, the requester is treated as making a new request.
- Simultaneous requests: round-robin only, no fixed priority. Starvation-free: every requester waits at most NREQ-1 transactions.
- Async reset mid-transaction: command lines drop immediately, no ack is issued, rr=0.

Optional Feature:
- Macro: MONITOR_CHANNEL_ARBITER_TIMEOUT_EN.
- Defined: the timeout counter runs in WAIT and is cleared on each monwt. When it reaches TIMEOUT_CYC-1 with no strobe:
  - abort to DONE with err=1;
  - rdata is unchanged;
  - rr advances normally.
- Undefined: no counter; WAIT lasts until the strobes arrive and err is tied to 0.

Decomposition:
- Shared package monitor_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - CH_W=9 and WORD_W=15 constants;
  - channel number constants for the downlink and scalar channels.
- One sub-module: rr_arbiter (NREQ-wide round-robin priority pick giving a one-hot grant and an encoded index from req and rr). Reused by other host-side arbiters.

Test Plan:
- Single read: req[0], ch=9'o30, monwt every 4 clk, mdata=15'h1234 on the 2nd strobe -> mrch=1 and ch=030 held through WAIT; ack[0] pulse; rdata=15'h1234; err=0; mwch never set.
- Single write: req[1], we=1, ch=9'o10, wdata=15'h5A5A -> mwch=1 and mwl=5A5A for 2 strobes; ack[1]; rdata unchanged; one idle cycle afterwards.
- Contention: req=3'b111 held continuously -> grant order 0,1,2,0,1,2, each ack separated by a full transaction; no requester is granted twice in a row.
- Boundary: monwt in the ISSUE cycle plus req[0] dropped mid-WAIT -> that ISSUE strobe is not counted; the transaction completes and ack[0] still pulses.
- Reset mid-WAIT: assert rst during a read -> mrch=0, busy=0 in the same cycle; no ack; the next grant after reset starts at index 0.
- Timeout (macro defined, TIMEOUT_CYC=16): monwt stops after 1 strobe -> ack with err=1 exactly 16 cycles after the last strobe; rdata unchanged. Macro undefined -> busy stays 1 indefinitely.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and constants for the AGC monitor channel interface logic.
package monitor_pkg;

  localparam int CH_W   = 9;
  localparam int WORD_W = 15;

  // Frequently scheduled monitor channels (octal AGC channel numbers).
  localparam logic [CH_W-1:0] CH_SCALER_HI = 9'o003;
  localparam logic [CH_W-1:0] CH_SCALER_LO = 9'o004;
  localparam logic [CH_W-1:0] CH_DNTM1     = 9'o034;
  localparam logic [CH_W-1:0] CH_DNTM2     = 9'o035;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/monitor_channel_arbiter_if.sv
// Requester-side and AGC-side signals of the monitor channel arbiter.
interface monitor_channel_arbiter_if #(
  parameter int NREQ = 3
);
  import monitor_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*CH_W-1:0]   req_ch;
  logic [NREQ*WORD_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic [WORD_W-1:0]      rdata;
  logic                   busy;
  logic                   monwt;
  logic [WORD_W-1:0]      mdata;
  logic                   mrch;
  logic                   mwch;
  logic [CH_W-1:0]        ch;
  logic [WORD_W-1:0]      mwl;

  modport slave (
    input  req, req_we, req_ch, req_wdata, monwt, mdata,
    output ack, err, rdata, busy, mrch, mwch, ch, mwl
  );

  modport master (
    output req, req_we, req_ch, req_wdata, monwt, mdata,
    input  ack, err, rdata, busy, mrch, mwch, ch, mwl
  );

endinterface

// File: rtl/monitor_channel_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after index rr (wrapping), as one-hot and index.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             off;
  int             sum;

  assign req_dbl = {req, req};
  assign any     = |req;

  always_comb begin
    req_rot = N'(req_dbl >> rr);
    off     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = i;
    end
    sum = int'(rr) + off;
    if (sum >= N) sum = sum - N;
    idx   = any ? IDX_W'(sum) : '0;
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/monitor_channel_arbiter.sv
// Round-robin scheduler of MRCH/MWCH cycles on the AGC monitor interface.
// Optional inter-strobe timeout abort: define MONITOR_CHANNEL_ARBITER_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for a request; grant and latch on the first one seen
//   ISSUE | command driven, strobe/timeout counters cleared, monwt ignored
//   WAIT  | command held, counting monwt strobes
//   DONE  | command released, ack (and err) to the grantee, rr advanced
module monitor_channel_arbiter
  import monitor_pkg::*;
#(
  parameter int NREQ         = 3,  // must match the interface instance
  parameter int HOLD_STROBES = 2
`ifdef MONITOR_CHANNEL_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC  = 1024
`endif
) (
  input logic clk,
  input logic rst,
  monitor_channel_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int SCNT_W = $clog2(HOLD_STROBES + 1);

  mon_state_e        state, state_nxt;
  logic [IDX_W-1:0]  rr, gnt_idx, pick_idx;
  logic [NREQ-1:0]   gnt_oh, pick_oh;
  logic              pick_any;
  logic              pick_we, we_q;
  logic [CH_W-1:0]   pick_ch, ch_q;
  logic [WORD_W-1:0] pick_wdata, wdata_q, rdata_q;
  logic [SCNT_W-1:0] scnt;
  logic              last_strobe, timeout_hit, abort_q;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req),
    .rr    (rr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_we    = 1'b0;
    pick_ch    = '0;
    pick_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_we    = bus.req_we[i];
        pick_ch    = bus.req_ch[i*CH_W +: CH_W];
        pick_wdata = bus.req_wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  assign last_strobe = (state == WAIT) && bus.monwt && (scnt == SCNT_W'(HOLD_STROBES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.mrch  = 1'b0;
    bus.mwch  = 1'b0;
    bus.ch    = '0;
    bus.mwl   = '0;
    bus.ack   = '0;
    bus.err   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = ISSUE;
      end
      ISSUE, WAIT: begin
        bus.busy = 1'b1;
        bus.mrch = ~we_q;
        bus.mwch = we_q;
        bus.ch   = ch_q;
        bus.mwl  = we_q ? wdata_q : '0;
        if (state == ISSUE)                   state_nxt = WAIT;
        else if (last_strobe || timeout_hit)  state_nxt = DONE;
      end
      DONE: begin
        bus.ack   = gnt_oh;
        bus.err   = abort_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr      <= '0;
      gnt_idx <= '0;
      gnt_oh  <= '0;
      we_q    <= 1'b0;
      ch_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      scnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_idx <= pick_idx;
            gnt_oh  <= pick_oh;
            we_q    <= pick_we;
            ch_q    <= pick_ch;
            wdata_q <= pick_wdata;
          end
        end
        ISSUE: scnt <= '0;
        WAIT: begin
          if (bus.monwt) scnt <= scnt + SCNT_W'(1);
          if (last_strobe && !we_q) rdata_q <= bus.mdata;
        end
        DONE: rr <= IDX_W'(rr_next(int'(gnt_idx), NREQ));
        default: ;
      endcase
    end
  end

  assign bus.rdata = rdata_q;

`ifdef MONITOR_CHANNEL_ARBITER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);

  logic [TCNT_W-1:0] tcnt;

  // Leave WAIT on the edge where the count reaches TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles after the last strobe.
  assign timeout_hit = (state == WAIT) && !bus.monwt && (tcnt == TCNT_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt    <= '0;
      abort_q <= 1'b0;
    end else if (state == ISSUE) begin
      tcnt    <= '0;
      abort_q <= 1'b0;
    end else if (state == WAIT) begin
      if (bus.monwt) tcnt <= '0;
      else           tcnt <= tcnt + TCNT_W'(1);
      if (timeout_hit) abort_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort_q     = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_channel_arbiter.sv
// Directed self-checking bench for monitor_channel_arbiter (NREQ=3, HOLD_STROBES=2).
module tb_monitor_channel_arbiter;
  import monitor_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  monitor_channel_arbiter_if #(.NREQ(NREQ)) bus ();

  monitor_channel_arbiter #(
    .NREQ         (NREQ),
    .HOLD_STROBES (2)
`ifdef MONITOR_CHANNEL_ARBITER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC  (16)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT in ISSUE; drives monwt/mdata until ack or max_cyc.
  task automatic run_txn(input int period, input int first, input int n_strobes,
                         input int data_at, input logic [14:0] data,
                         input int drop_at, input logic [2:0] drop_mask, input int max_cyc,
                         output int ack_cyc, output logic [2:0] ack_v, output logic err_v,
                         output logic stable, output logic rd_seen, output logic wr_seen);
    logic mrch0, mwch0;
    logic [8:0] ch0;
    logic [14:0] mwl0;
    int ns;
    mrch0 = bus.mrch; mwch0 = bus.mwch; ch0 = bus.ch; mwl0 = bus.mwl;
    stable = 1'b1; rd_seen = bus.mrch; wr_seen = bus.mwch;
    ack_cyc = -1; ack_v = '0; err_v = 1'b0; ns = 0;
    for (int c = 0; c < max_cyc; c++) begin
      bus.monwt = (c >= first) && (((c - first) % period) == 0) && (ns < n_strobes);
      if (bus.monwt) ns++;
      bus.mdata = (bus.monwt && ns == data_at) ? data : (data ^ 15'h7FFF);
      if (c == drop_at) bus.req = bus.req & ~drop_mask;
      tick();
      rd_seen |= bus.mrch;
      wr_seen |= bus.mwch;
      if (bus.ack != '0) begin
        ack_cyc = c; ack_v = bus.ack; err_v = bus.err;
        break;
      end
      if (bus.mrch !== mrch0 || bus.mwch !== mwch0 || bus.ch !== ch0 || bus.mwl !== mwl0)
        stable = 1'b0;
    end
    bus.monwt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0; bus.req_we = '0; bus.req_ch = '0; bus.req_wdata = '0;
    bus.monwt = 1'b0; bus.mdata = '0;
    repeat (3) tick();
    n_cmp++; if (bus.ack !== 3'b000)  begin n_fail++; $display("FAIL reset_ack: got %b want 000", bus.ack); end
    n_cmp++; if (bus.err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.rdata !== 15'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
    n_cmp++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.mrch !== 1'b0 || bus.mwch !== 1'b0)
      begin n_fail++; $display("FAIL reset_cmd: got mrch=%b mwch=%b want 0 0", bus.mrch, bus.mwch); end
    n_cmp++; if (bus.ch !== 9'h0 || bus.mwl !== 15'h0)
      begin n_fail++; $display("FAIL reset_bus: got ch=%o mwl=%h want 0 0", bus.ch, bus.mwl); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_single_read();
    int ac; logic [2:0] av; logic ev, st, rd, wr;
    bus.req_ch = {9'o0, 9'o0, 9'o30}; bus.req_we = 3'b000; bus.req = 3'b001;
    tick();
    n_cmp++; if (bus.mrch !== 1'b1 || bus.ch !== 9'o30 || bus.busy !== 1'b1)
      begin n_fail++; $display("FAIL read_issue: got mrch=%b ch=%o busy=%b want 1 030 1", bus.mrch, bus.ch, bus.busy); end
    run_txn(4, 3, 2, 2, 15'h1234, -1, 3'b000, 40, ac, av, ev, st, rd, wr);
    bus.req = 3'b000;
    n_cmp++; if (ac !== 7)       begin n_fail++; $display("FAIL read_latency: got %0d want 7", ac); end
    n_cmp++; if (av !== 3'b001)  begin n_fail++; $display("FAIL read_ack: got %b want 001", av); end
    n_cmp++; if (ev !== 1'b0)    begin n_fail++; $display("FAIL read_err: got %b want 0", ev); end
    n_cmp++; if (st !== 1'b1)    begin n_fail++; $display("FAIL read_hold: got stable=%b want 1", st); end
    n_cmp++; if (wr !== 1'b0)    begin n_fail++; $display("FAIL read_no_mwch: got %b want 0", wr); end
    n_cmp++; if (bus.rdata !== 15'h1234) begin n_fail++; $display("FAIL read_rdata: got %h want 1234", bus.rdata); end
    n_cmp++; if (bus.mrch !== 1'b0 || bus.ch !== 9'h0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL read_done_release: got mrch=%b ch=%o busy=%b want 0 0 0", bus.mrch, bus.ch, bus.busy); end
    tick();
    n_cmp++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL read_ack_pulse: got %b want 000", bus.ack); end
  endtask

  task automatic test_single_write();
    int ac; logic [2:0] av; logic ev, st, rd, wr;
    bus.req_ch = {9'o0, 9'o10, 9'o0}; bus.req_wdata = {15'h0, 15'h5A5A, 15'h0};
    bus.req_we = 3'b010; bus.req = 3'b010;
    tick();
    n_cmp++; if (bus.mwch !== 1'b1 || bus.mrch !== 1'b0 || bus.mwl !== 15'h5A5A || bus.ch !== 9'o10)
      begin n_fail++; $display("FAIL write_issue: got mwch=%b mrch=%b mwl=%h ch=%o want 1 0 5a5a 010",
                                bus.mwch, bus.mrch, bus.mwl, bus.ch); end
    run_txn(4, 3, 2, 2, 15'h0BAD, -1, 3'b000, 40, ac, av, ev, st, rd, wr);
    bus.req = 3'b000; bus.req_we = 3'b000;
    n_cmp++; if (ac !== 7)       begin n_fail++; $display("FAIL write_latency: got %0d want 7", ac); end
    n_cmp++; if (av !== 3'b010)  begin n_fail++; $display("FAIL write_ack: got %b want 010", av); end
    n_cmp++; if (st !== 1'b1 || rd !== 1'b0)
      begin n_fail++; $display("FAIL write_hold: got stable=%b mrch_seen=%b want 1 0", st, rd); end
    n_cmp++; if (bus.rdata !== 15'h1234) begin n_fail++; $display("FAIL write_rdata_kept: got %h want 1234", bus.rdata); end
    n_cmp++; if (bus.mwch !== 1'b0 || bus.mwl !== 15'h0)
      begin n_fail++; $display("FAIL write_done_release: got mwch=%b mwl=%h want 0 0", bus.mwch, bus.mwl); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.mwch !== 1'b0)
      begin n_fail++; $display("FAIL write_idle_gap: got busy=%b mwch=%b want 0 0", bus.busy, bus.mwch); end
  endtask

  task automatic test_issue_strobe_and_drop();
    int ac; logic [2:0] av; logic ev, st, rd, wr;
    bus.req_ch = {9'o0, 9'o0, CH_DNTM1}; bus.req = 3'b001;
    tick();
    run_txn(2, 0, 3, 3, 15'h2ABC, 3, 3'b001, 40, ac, av, ev, st, rd, wr);
    n_cmp++; if (ac !== 4)      begin n_fail++; $display("FAIL boundary_latency: got %0d want 4", ac); end
    n_cmp++; if (av !== 3'b001) begin n_fail++; $display("FAIL boundary_ack: got %b want 001", av); end
    n_cmp++; if (bus.rdata !== 15'h2ABC) begin n_fail++; $display("FAIL boundary_rdata: got %h want 2abc", bus.rdata); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic saw_ack;
    bus.req_ch = {CH_SCALER_LO, 9'o0, 9'o0}; bus.req = 3'b100;
    tick();
    bus.monwt = 1'b1;
    tick();
    bus.monwt = 1'b0;
    tick();
    n_cmp++; if (bus.mrch !== 1'b1 || bus.busy !== 1'b1)
      begin n_fail++; $display("FAIL rstwait_active: got mrch=%b busy=%b want 1 1", bus.mrch, bus.busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.mrch !== 1'b0 || bus.busy !== 1'b0 || bus.ch !== 9'h0)
      begin n_fail++; $display("FAIL rstwait_drop: got mrch=%b busy=%b ch=%o want 0 0 0", bus.mrch, bus.busy, bus.ch); end
    bus.req = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    saw_ack = 1'b0;
    repeat (6) begin
      tick();
      if (bus.ack !== 3'b000) saw_ack = 1'b1;
    end
    n_cmp++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_ack: got saw_ack=%b want 0", saw_ack); end
    n_cmp++; if (bus.rdata !== 15'h0) begin n_fail++; $display("FAIL rstwait_rdata: got %h want 0000", bus.rdata); end
  endtask

  task automatic test_contention();
    int ac; logic [2:0] av; logic ev, st, rd, wr;
    logic [2:0] exp_oh;
    logic [8:0] exp_ch;
    logic [14:0] exp_data;
    bus.req_ch = {9'o3, 9'o2, 9'o1}; bus.req_we = 3'b000; bus.req = 3'b111;
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_oh   = 3'b001 << (k % 3);
      exp_ch   = 9'((k % 3) + 1);
      exp_data = 15'h0100 + 15'(k);
      n_cmp++; if (bus.ch !== exp_ch)
        begin n_fail++; $display("FAIL contend_ch[%0d]: got %o want %o", k, bus.ch, exp_ch); end
      run_txn(1, 0, 3, 3, exp_data, -1, 3'b000, 20, ac, av, ev, st, rd, wr);
      n_cmp++; if (av !== exp_oh) begin n_fail++; $display("FAIL contend_ack[%0d]: got %b want %b", k, av, exp_oh); end
      n_cmp++; if (ac !== 2)      begin n_fail++; $display("FAIL contend_latency[%0d]: got %0d want 2", k, ac); end
      n_cmp++; if (bus.rdata !== exp_data)
        begin n_fail++; $display("FAIL contend_rdata[%0d]: got %h want %h", k, bus.rdata, exp_data); end
      if (k == 5) bus.req = 3'b000;
      tick();
      n_cmp++; if (bus.busy !== 1'b0 || bus.mrch !== 1'b0)
        begin n_fail++; $display("FAIL contend_gap[%0d]: got busy=%b mrch=%b want 0 0", k, bus.busy, bus.mrch); end
      if (k < 5) tick();
    end
  endtask

  task automatic test_timeout();
    int ac; logic [2:0] av; logic ev, st, rd, wr;
    bus.req_ch = {9'o0, 9'o0, CH_SCALER_HI}; bus.req = 3'b001;
    tick();
`ifdef MONITOR_CHANNEL_ARBITER_TIMEOUT_EN
    run_txn(1, 2, 1, 2, 15'h0777, -1, 3'b000, 40, ac, av, ev, st, rd, wr);
    bus.req = 3'b000;
    n_cmp++; if (ac !== 17)     begin n_fail++; $display("FAIL timeout_latency: got %0d want 17", ac); end
    n_cmp++; if (av !== 3'b001) begin n_fail++; $display("FAIL timeout_ack: got %b want 001", av); end
    n_cmp++; if (ev !== 1'b1)   begin n_fail++; $display("FAIL timeout_err: got %b want 1", ev); end
    n_cmp++; if (bus.rdata !== 15'h0105) begin n_fail++; $display("FAIL timeout_rdata: got %h want 0105", bus.rdata); end
    tick();
    n_cmp++; if (bus.err !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL timeout_after: got err=%b busy=%b want 0 0", bus.err, bus.busy); end
`else
    run_txn(1, 2, 1, 2, 15'h0777, -1, 3'b000, 60, ac, av, ev, st, rd, wr);
    n_cmp++; if (ac !== -1)     begin n_fail++; $display("FAIL notimeout_no_ack: got %0d want -1", ac); end
    n_cmp++; if (bus.busy !== 1'b1 || bus.mrch !== 1'b1)
      begin n_fail++; $display("FAIL notimeout_busy: got busy=%b mrch=%b want 1 1", bus.busy, bus.mrch); end
    run_txn(1, 0, 1, 1, 15'h0555, -1, 3'b000, 10, ac, av, ev, st, rd, wr);
    bus.req = 3'b000;
    n_cmp++; if (ac !== 0 || av !== 3'b001 || ev !== 1'b0)
      begin n_fail++; $display("FAIL notimeout_finish: got cyc=%0d ack=%b err=%b want 0 001 0", ac, av, ev); end
    n_cmp++; if (bus.rdata !== 15'h0555) begin n_fail++; $display("FAIL notimeout_rdata: got %h want 0555", bus.rdata); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL notimeout_idle: got busy=%b want 0", bus.busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_issue_strobe_and_drop();
    test_reset_mid_wait();
    test_contention();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
